// File: rtl/dump_serializer.sv
// Serialises a snapshot of the register bank and/or data memory into a byte
// stream for a UART TX FIFO: word 0 first, most-significant byte first.
module dump_serializer #(
  parameter int UART_BUS_SIZE          = 8,
  parameter int REGISTER_SIZE          = 32,
  parameter int REGISTER_BANK_BUS_SIZE = 1024,
  parameter int MEMORY_DATA_BUS_SIZE   = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [1:0]                        i_select,
  input  logic                              i_uart_full,
  input  logic [REGISTER_BANK_BUS_SIZE-1:0] i_registers_content,
  input  logic [MEMORY_DATA_BUS_SIZE-1:0]   i_memory_content,
  output logic                              o_uart_wr,
  output logic [UART_BUS_SIZE-1:0]          o_uart_data_wr,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int REG_OFF_W = $clog2(REGISTER_BANK_BUS_SIZE);
  localparam int MEM_OFF_W = $clog2(MEMORY_DATA_BUS_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_REGS = 2'd1,
    SEND_MEM  = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [6:0]                        idx_q, idx_d;
  logic                              dump_mem_q, dump_mem_d;
  logic                              capture;
  logic                              last_byte;
  logic [REGISTER_BANK_BUS_SIZE-1:0] regs_snap;
  logic [MEMORY_DATA_BUS_SIZE-1:0]   mem_snap;
  logic [REG_OFF_W-1:0]              reg_off;
  logic [MEM_OFF_W-1:0]              mem_off;
  logic [UART_BUS_SIZE-1:0]          regs_byte;
  logic [UART_BUS_SIZE-1:0]          mem_byte;

  // Bit offset of byte idx: idx[6:2] selects the word, idx[1:0] counts down
  // from the most-significant byte lane.
  function automatic logic [31:0] byte_offset(input logic [6:0] idx);
    byte_offset = 32'(idx[6:2]) * 32'(REGISTER_SIZE)
                + 32'(REGISTER_SIZE - UART_BUS_SIZE)
                - 32'(idx[1:0]) * 32'(UART_BUS_SIZE);
  endfunction

  assign last_byte = (idx_q == 7'd127);
  assign reg_off   = REG_OFF_W'(byte_offset(idx_q));
  assign mem_off   = MEM_OFF_W'(byte_offset(idx_q));
  assign regs_byte = regs_snap[reg_off +: UART_BUS_SIZE];
  assign mem_byte  = mem_snap[mem_off +: UART_BUS_SIZE];

  assign o_uart_wr = ((state_q == SEND_REGS) || (state_q == SEND_MEM)) && !i_uart_full;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);

  always_comb begin
    o_uart_data_wr = '0;
    case (state_q)
      SEND_REGS: o_uart_data_wr = regs_byte;
      SEND_MEM:  o_uart_data_wr = mem_byte;
      default:   o_uart_data_wr = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_mem_d = dump_mem_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          capture    = 1'b1;
          idx_d      = 7'd0;
          dump_mem_d = i_select[1];
          if (i_select[0])      state_d = SEND_REGS;
          else if (i_select[1]) state_d = SEND_MEM;
          else                  state_d = DONE;
        end
      end
      SEND_REGS: begin
        if (o_uart_wr) begin
          idx_d = idx_q + 7'd1;
          if (last_byte) state_d = dump_mem_q ? SEND_MEM : DONE;
        end
      end
      SEND_MEM: begin
        if (o_uart_wr) begin
          idx_d = idx_q + 7'd1;
          if (last_byte) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      idx_q      <= 7'd0;
      dump_mem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dump_mem_q <= dump_mem_d;
    end
  end

  // Snapshot storage is pure data and is never reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      regs_snap <= i_registers_content;
      mem_snap  <= i_memory_content;
    end
  end

endmodule

// File: tb/tb_dump_serializer.sv
// Scoreboard bench for dump_serializer: stimulus pushes the expected byte
// stream, a negedge monitor checks every presented byte and strobe.
module tb_dump_serializer;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [1:0]    i_select;
  logic          i_uart_full;
  logic [1023:0] i_registers_content;
  logic [1023:0] i_memory_content;
  logic          o_uart_wr;
  logic [7:0]    o_uart_data_wr;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  dump_serializer #(
    .UART_BUS_SIZE(8),
    .REGISTER_SIZE(32),
    .REGISTER_BANK_BUS_SIZE(1024),
    .MEMORY_DATA_BUS_SIZE(1024)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_select(i_select),
    .i_uart_full(i_uart_full),
    .i_registers_content(i_registers_content),
    .i_memory_content(i_memory_content),
    .o_uart_wr(o_uart_wr),
    .o_uart_data_wr(o_uart_data_wr),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [31:0] regs_w[32];
  logic [31:0] mem_w[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_contents();
    for (int k = 0; k < 32; k++) begin
      i_registers_content[32*k +: 32] = regs_w[k];
      i_memory_content[32*k +: 32]    = mem_w[k];
    end
  endtask

  // Reference stream: each selected region, words 0..31, bytes MSB first.
  task automatic push_expected(input logic [1:0] sel);
    if (sel[0])
      for (int k = 0; k < 32; k++)
        for (int b = 3; b >= 0; b--) exp_q.push_back(regs_w[k][8*b +: 8]);
    if (sel[1])
      for (int k = 0; k < 32; k++)
        for (int b = 3; b >= 0; b--) exp_q.push_back(mem_w[k][8*b +: 8]);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (!o_busy) begin
        check("idle_outputs", {22'd0, o_uart_wr, o_done, o_uart_data_wr}, 32'd0);
      end else if (o_done) begin
        check("done_outputs", {23'd0, o_uart_wr, o_uart_data_wr}, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(o_uart_wr), 32'd0);
      end else begin
        check("byte", 32'(o_uart_data_wr), 32'(exp_q[0]));
        check("strobe", 32'(o_uart_wr), 32'(!i_uart_full));
        if (o_uart_wr) void'(exp_q.pop_front());
      end
    end
  end

  // mode 0: no backpressure, 1: full for 5 cycles after the 10th write,
  // 2: random backpressure. abort_after > 0 resets after that many writes.
  task automatic dump(input logic [1:0] sel, input int mode, input bit mutate,
                      input int abort_after);
    int remaining;
    int writes;
    int stalls;
    bit full;
    drive_contents();
    push_expected(sel);
    remaining = (sel[0] ? 128 : 0) + (sel[1] ? 128 : 0);
    i_select    = sel;
    i_uart_full = 1'b0;
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    writes  = 0;
    stalls  = 0;
    while (remaining > 0) begin
      if (abort_after > 0 && writes == abort_after) begin
        i_reset     = 1'b1;
        i_uart_full = 1'b0;
        i_start     = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_start = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_strobe", 32'(o_uart_wr), 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          check("abort_no_done", 32'(o_done), 32'd0);
        end
        return;
      end
      case (mode)
        1:       full = (writes == 10) && (stalls < 5);
        2:       full = ($urandom_range(0, 3) == 0);
        default: full = 1'b0;
      endcase
      i_uart_full = full;
      if (full) stalls++;
      else begin
        remaining--;
        writes++;
      end
      if (mutate) begin
        i_registers_content = {32{$urandom}};
        i_memory_content    = {32{$urandom}};
        i_select            = 2'($urandom_range(0, 3));
        i_start             = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    i_start     = 1'b0;
    i_uart_full = 1'($urandom_range(0, 1));
    check("done_pulse", 32'(o_done), 32'd1);
    check("done_busy", 32'(o_busy), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    i_uart_full = 1'b0;
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("back_to_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic randomize_words();
    for (int k = 0; k < 32; k++) begin
      regs_w[k] = $urandom;
      mem_w[k]  = $urandom;
    end
  endtask

  initial begin
    i_reset             = 1'b1;
    i_start             = 1'b1;
    i_select            = 2'b11;
    i_uart_full         = 1'b0;
    i_registers_content = '0;
    i_memory_content    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_strobe", 32'(o_uart_wr), 32'd0);
    check("reset_data", 32'(o_uart_data_wr), 32'd0);
    i_start = 1'b0;
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 32; k++) begin
      regs_w[k] = 32'h1100_0000 + 32'(k);
      mem_w[k]  = 32'hA0B0_C000 + 32'(k);
    end
    dump(2'b01, 0, 1'b0, 0);
    dump(2'b11, 0, 1'b0, 0);
    dump(2'b10, 0, 1'b0, 0);
    dump(2'b01, 1, 1'b0, 0);
    randomize_words();
    dump(2'b11, 0, 1'b1, 0);
    dump(2'b01, 0, 1'b0, 40);
    dump(2'b01, 0, 1'b0, 0);
    dump(2'b00, 0, 1'b0, 0);
    for (int r = 0; r < 6; r++) begin
      randomize_words();
      dump(2'($urandom_range(0, 3)), 2, 1'($urandom_range(0, 1)), 0);
    end
    randomize_words();
    dump(2'b11, 2, 1'b0, 100);
    dump(2'b11, 2, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dump_serializer.md
DUMP_SERIALIZER -- requirements
Module: dump_serializer

Interface
REQ-001 SHALL have parameter UART_BUS_SIZE, default 8, byte width sent to UART TX FIFO.
REQ-002 SHALL have parameter REGISTER_SIZE, default 32, width of one register/memory word.
REQ-003 SHALL have parameter REGISTER_BANK_BUS_SIZE, default 1024, flattened register-bank width (32 words).
REQ-004 SHALL have parameter MEMORY_DATA_BUS_SIZE, default 1024, flattened data-memory width (32 words).
REQ-005 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_start  input  1  dump request, sampled only in IDLE.
REQ-008 SHALL have port i_select  input  2  bit0 = dump registers, bit1 = dump memory.
REQ-009 SHALL have port i_uart_full  input  1  UART TX FIFO full.
REQ-010 SHALL have port i_registers_content  input  REGISTER_BANK_BUS_SIZE  register bank, word k at bits [32k+31:32k].
REQ-011 SHALL have port i_memory_content  input  MEMORY_DATA_BUS_SIZE  data memory, same word packing.
REQ-012 SHALL have port o_uart_wr  output  1  write strobe to UART TX FIFO.
REQ-013 SHALL have port o_uart_data_wr  output  UART_BUS_SIZE  byte to write.
REQ-014 SHALL have port o_busy  output  1  dump in progress.
REQ-015 SHALL have port o_done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SEND_REGS, SEND_MEM, DONE.
REQ-017 IDLE: on i_start=1 SHALL snapshot both content buses into internal registers and clear byte index; next state SEND_REGS if i_select[0], else SEND_MEM if i_select[1], else DONE.
REQ-018 Serialized content SHALL be the snapshot only; input bus changes after the start cycle SHALL not affect output bytes.
REQ-019 Order SHALL be word 0 first up to word 31; within a word most-significant byte first ([31:24], [23:16], [15:8], [7:0]).
REQ-020 o_uart_wr SHALL be combinational: 1 iff state is SEND_REGS or SEND_MEM and i_uart_full=0.
REQ-021 o_uart_data_wr SHALL always present the byte at current index of the active region; 0 in IDLE and DONE.
REQ-022 7-bit byte index SHALL increment only in cycles where o_uart_wr=1; held while i_uart_full=1.
REQ-023 When a byte with index 127 is written, index SHALL wrap to 0; SEND_REGS goes to SEND_MEM if i_select[1] latched, else DONE; SEND_MEM goes to DONE.
REQ-024 i_select SHALL be latched at start; changes during a dump SHALL be ignored.
REQ-025 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-026 o_busy SHALL be 1 in SEND_REGS, SEND_MEM and DONE; 0 in IDLE.
REQ-027 i_start while not IDLE SHALL be ignored (no restart, no re-snapshot).
REQ-028 Latency without backpressure: start accepted cycle N -> first write cycle N+1; 128 writes per region, consecutive; o_done at cycle after last write.
REQ-029 i_select=00: no writes; o_done=1 at cycle N+1.

Reset
REQ-030 i_reset=1 SHALL force IDLE, index 0, latched select 00, at next rising edge, overriding any other input including i_start.
REQ-031 After reset: o_uart_wr=0, o_uart_data_wr=0, o_busy=0, o_done=0.
REQ-032 Reset mid-dump SHALL abort with no further writes and no o_done pulse.

Verification
REQ-033 Registers word k = 0x11000000+k, i_select=01, i_uart_full=0, start at N -> 128 writes at N+1..N+128, bytes 11 00 00 00, 11 00 00 01, ..., 11 00 00 1F; o_done=1 at N+129 only.
REQ-034 i_select=11, memory word k = 0xA0B0C000+k -> 256 writes; byte 128 = 0xA0, byte 131 = 0x00, last byte = 0x1F; o_done at N+257.
REQ-035 i_uart_full=1 for 5 cycles after the 10th write -> no strobe those cycles, o_uart_data_wr held at byte 10, sequence resumes unchanged; o_done delayed by exactly 5 cycles.
REQ-036 Change i_registers_content and i_select, and pulse i_start, during a dump -> output bytes and region set unchanged from snapshot.
REQ-037 Assert i_reset for one cycle after 40 writes -> next cycle IDLE, o_busy=0, no o_done; fresh start then dumps from byte 0.
REQ-038 i_select=00 start -> zero writes, o_busy=1 and o_done=1 for exactly one cycle.
